dtree_feature_sequencer: RTL

DTREE_FEATURE_SEQUENCER -- requirements
Module: dtree_feature_sequencer

---
 rtl/dtree_feature_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/dtree_feature_sequencer.sv
// Feature-frame sequencer for a combinational decision-tree classifier:
// gathers N_FEAT bytes, lets the tree settle, then holds the captured class.
module dtree_feature_sequencer #(
  parameter int N_FEAT  = 7,
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 5,
  parameter int SETTLE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_sof,
  output logic                     s_ready,
  output logic [N_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [CLASS_W-1:0]       cls_in,
  output logic [CLASS_W-1:0]       m_class,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     sof_err
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_HOLD} state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           wr_slot;
  logic [CNT_W-1:0]           cnt;
  logic [N_FEAT*FEAT_W-1:0]   slots;
  logic                       xfer, accept, discard, restart_err, frame_done, settle_last;

  // rst_n gates s_ready so nothing is offered while reset is held
  assign s_ready  = rst_n && (state == ST_LOAD);
  assign busy     = (state == ST_SETTLE) || (state == ST_HOLD);
  assign m_valid  = (state == ST_HOLD);
  assign feat_vec = slots;

  assign xfer        = s_valid && s_ready;
  assign accept      = xfer && (s_sof || (idx != '0));
  assign discard     = xfer && !s_sof && (idx == '0);
  assign restart_err = xfer && s_sof && (idx != '0);
  assign wr_slot     = s_sof ? '0 : idx;
  assign frame_done  = accept && (wr_slot == IDX_W'(N_FEAT - 1));
  assign settle_last = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (frame_done)  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_nxt = ST_HOLD;
      ST_HOLD:   if (m_ready)     state_nxt = ST_LOAD;
      default:                    state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      cnt     <= '0;
      slots   <= '0;
      m_class <= '0;
      sof_err <= 1'b0;
    end else begin
      sof_err <= restart_err || discard;
      if (accept) begin
        slots[int'(wr_slot)*FEAT_W +: FEAT_W] <= s_data;
        idx <= frame_done ? '0 : wr_slot + IDX_W'(1);
      end
      // counter is loaded with SETTLE; the cycle holding 1 is the capture cycle
      if (frame_done)
        cnt <= CNT_W'(SETTLE);
      else if (state == ST_SETTLE)
        cnt <= cnt - CNT_W'(1);
      if ((state == ST_SETTLE) && settle_last)
        m_class <= cls_in;
    end
  end

endmodule
